// File: rtl/ifetch_if.sv
// Fetch-stage bundle: decode control, ROM address/data and the IF/ID register outputs.
// The fetch_fault line exists only when IFETCH_ALIGN_CHECK_EN is defined.
interface ifetch_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        active;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  // Slave side is the fetch unit itself.
  modport slave (
    input  stall, branch_taken, branch_target, rom_instr,
    output rom_addr, if_instr, if_pc, if_valid, active
`ifdef IFETCH_ALIGN_CHECK_EN
    , output fetch_fault
`endif
  );

  modport master (
    output stall, branch_taken, branch_target, rom_instr,
    input  rom_addr, if_instr, if_pc, if_valid, active
`ifdef IFETCH_ALIGN_CHECK_EN
    , input fetch_fault
`endif
  );
endinterface

// File: rtl/ifetch_unit.sv
// MIPS instruction-fetch stage: PC, IF/ID register, delay-slot branch sequencing and halt on jump to zero.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned branch targets halt fetch and raise fetch_fault.
module ifetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst_n,
  ifetch_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_if_instr, w_if_instr_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic        r_active, w_active_nxt;
  logic        r_pending, w_pending_nxt;
  logic [31:0] r_pend_tgt, w_pend_tgt_nxt;
  logic        w_have_tgt;
  logic [31:0] w_tgt_raw;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        r_fault, w_fault_nxt;
`endif

  // A fresh branch pulse always beats a target parked during a stall.
  assign w_have_tgt = bus.branch_taken | r_pending;
  assign w_tgt_raw  = bus.branch_taken ? bus.branch_target : r_pend_tgt;

  // Next-state and next-register values for the fetch FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    w_if_valid_nxt = r_if_valid;
    w_active_nxt   = r_active;
    w_pending_nxt  = r_pending;
    w_pend_tgt_nxt = r_pend_tgt;
`ifdef IFETCH_ALIGN_CHECK_EN
    w_fault_nxt    = r_fault;
`endif
    case (r_state)
      ST_RUN: begin
        if (bus.stall) begin
          if (bus.branch_taken) begin
            w_pending_nxt  = 1'b1;
            w_pend_tgt_nxt = bus.branch_target;
          end else begin
            w_pending_nxt  = r_pending;
          end
        end else if (r_pc == HALT_ADDR) begin
          // Delay slot of the jump was captured on the previous edge.
          w_state_nxt    = ST_HALTED;
          w_if_valid_nxt = 1'b0;
          w_active_nxt   = 1'b0;
          w_pending_nxt  = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        end else if (w_have_tgt && (w_tgt_raw[1:0] != 2'b00)) begin
          w_state_nxt    = ST_HALTED;
          w_if_valid_nxt = 1'b0;
          w_active_nxt   = 1'b0;
          w_pending_nxt  = 1'b0;
          w_fault_nxt    = 1'b1;
`endif
        end else begin
          w_if_instr_nxt = bus.rom_instr;
          w_if_pc_nxt    = r_pc;
          w_if_valid_nxt = 1'b1;
          w_pending_nxt  = 1'b0;
          w_pc_nxt       = w_have_tgt ? (w_tgt_raw & 32'hFFFF_FFFC) : (r_pc + 32'd4);
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt    = ST_HALTED;
        w_if_valid_nxt = 1'b0;
        w_active_nxt   = 1'b0;
      end
    endcase
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_VECTOR;
      r_if_instr <= 32'd0;
      r_if_pc    <= 32'd0;
      r_if_valid <= 1'b0;
      r_active   <= 1'b1;
      r_pending  <= 1'b0;
      r_pend_tgt <= 32'd0;
`ifdef IFETCH_ALIGN_CHECK_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_active   <= w_active_nxt;
      r_pending  <= w_pending_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
`ifdef IFETCH_ALIGN_CHECK_EN
      r_fault    <= w_fault_nxt;
`endif
    end
  end

  assign bus.rom_addr = r_pc;
  assign bus.if_instr = r_if_instr;
  assign bus.if_pc    = r_if_pc;
  assign bus.if_valid = r_if_valid;
  assign bus.active   = r_active;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign bus.fetch_fault = r_fault;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: directed scenarios then randomized decode traffic vs a reference model.
module tb_ifetch_unit;
  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_if bus();

  ifetch_unit #(.RESET_VECTOR(RV), .HALT_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.rom_instr = rom_fn(bus.rom_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic        valid;
    logic        active;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_instr, m_ifpc, m_ptgt;
  logic        m_valid, m_active, m_fault, m_halted, m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_instr = 32'd0; m_ifpc = 32'd0; m_ptgt = 32'd0;
    m_valid = 1'b0; m_active = 1'b1; m_fault = 1'b0; m_halted = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic b, input logic [31:0] t);
    logic        use_t;
    logic [31:0] tg;
    if (m_halted) begin
      // frozen until reset
    end else if (s) begin
      if (b) begin m_pend = 1'b1; m_ptgt = t; end
    end else if (m_pc == 32'd0) begin
      m_halted = 1'b1; m_valid = 1'b0; m_active = 1'b0; m_pend = 1'b0;
    end else begin
      use_t = b || m_pend;
      tg = b ? t : m_ptgt;
      m_pend = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      if (use_t && (tg % 32'd4 != 32'd0)) begin
        m_fault = 1'b1; m_halted = 1'b1; m_valid = 1'b0; m_active = 1'b0;
        return;
      end
`endif
      m_instr = rom_fn(m_pc);
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = use_t ? (tg - (tg % 32'd4)) : (m_pc + 32'd4);
    end
  endtask

  // Called at a falling edge: drive, predict, queue expectation, wait one cycle.
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    exp_t e;
    bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
    model_step(s, b, t);
    e.pc = m_pc; e.instr = m_instr; e.ifpc = m_ifpc;
    e.valid = m_valid; e.active = m_active; e.fault = m_fault;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic free_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
  endtask

  // Called at a falling edge: asynchronous reset mid-cycle, then release before the next edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
    #1;
    model_reset();
    chk("rst_rom_addr", bus.rom_addr, RV);
    chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_active", {31'd0, bus.active}, 32'd1);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    chk("pre_edge_rom_addr", bus.rom_addr, RV);
  endtask

  // Monitor: compare DUT outputs after every edge that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rom_addr", bus.rom_addr, e.pc);
        chk("if_instr", bus.if_instr, e.instr);
        chk("if_pc", bus.if_pc, e.ifpc);
        chk("if_valid", {31'd0, bus.if_valid}, {31'd0, e.valid});
        chk("active", {31'd0, bus.active}, {31'd0, e.active});
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, e.fault});
`endif
      end
    end
  end

  initial begin
    logic        s, b;
    logic [31:0] t;
    int          r;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Stall hold, then a taken branch with its delay slot.
    free_n(2);
    step(1'b1, 1'b0, 32'd0); step(1'b1, 1'b0, 32'd0); step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hBFC0_0040);
    free_n(2);

    // Branch parked during a stall, overwrite, and fresh pulse beating pending.
    do_reset();
    free_n(3);
    step(1'b1, 1'b1, 32'hBFC0_0080);
    step(1'b1, 1'b0, 32'd0); step(1'b1, 1'b0, 32'd0);
    free_n(2);
    step(1'b1, 1'b1, 32'hBFC0_0100);
    step(1'b1, 1'b1, 32'hBFC0_0200);
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'hBFC0_0300);
    step(1'b0, 1'b1, 32'hBFC0_0400);
    free_n(1);

    // Wrap from FFFFFFFC to zero, halt, branch pulses ignored.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    free_n(3);
    step(1'b0, 1'b1, 32'hBFC0_0000);
    step(1'b1, 1'b1, 32'hBFC0_0010);
    free_n(2);

    // Mid-run reset at PC=BFC00010.
    do_reset();
    free_n(4);
    do_reset();

    // Misaligned target.
    step(1'b0, 1'b1, 32'hBFC0_0042);
    free_n(2);

    // Randomized episodes.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int i = 0; i < 200; i++) begin
        s = ($urandom_range(99) < 30);
        b = ($urandom_range(99) < 15);
        r = int'($urandom_range(99));
        t = RV + 32'($urandom_range(255)) * 32'd4;
        if (r < 10) t = t | 32'($urandom_range(3));
        if (r < 3) t = 32'd0;
        step(s, b, t);
      end
    end

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM address. Captures the returned 32-bit word into the IF/ID pipeline register.
- Implements MIPS branch-delay-slot sequencing, decode-requested stalls and the halt-on-jump-to-zero convention.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset
HALT_ADDR, 32'h00000000, PC value that stops fetch

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
stall  input  1  hold PC and IF/ID register this cycle
branch_taken  input  1  single-cycle pulse from decode: branch/jump in ID is taken
branch_target  input  32  target address, valid while branch_taken=1
rom_addr  output  32  byte address to ROM; combinational copy of PC
rom_instr  input  32  word returned combinationally by ROM for rom_addr
if_instr  output  32  IF/ID instruction
if_pc  output  32  IF/ID address of if_instr
if_valid  output  1  IF/ID holds a real instruction
active  output  1  CPU running; low once halted

Behaviour:
- Reset (rst_n=0, asynchronous):
  - PC=RESET_VECTOR, if_instr=0, if_pc=0, if_valid=0, active=1, pending=0, state=RUN.
  - Takes effect immediately, mid-cycle included. Fetch restarts at RESET_VECTOR on the first edge after release.
- rom_addr = PC, always. ROM is combinational. Latency: word at PC appears on if_instr one edge after PC is presented.
- States:
  - RUN: fetch.
  - HALTED: terminal until reset.
- RUN, stall=0, each edge:
  - if_instr<=rom_instr, if_pc<=PC, if_valid<=1.
  - PC<=next_pc.
- next_pc, in priority order:
  1. branch_target if branch_taken=1 this cycle.
  2. The pending target, if pending=1 (pending clears).
  3. Otherwise PC+4, wrapping modulo 2^32.
- Delay slot:
  - branch_taken arrives while the branch sits in ID, so the word being fetched that cycle is the delay slot.
  - The delay slot is captured normally; the target follows it.
  - No flush is ever generated.
- RUN, stall=1:
  - PC, if_instr, if_pc and if_valid hold.
  - If branch_taken=1, pending<=1 and the target is latched.
  - A second pulse while pending=1 overwrites the latched target.
  - On the first stall=0 edge, the delay slot is captured and PC<=latched target.
- Simultaneous branch_taken=1 and pending=1 with stall=0: the new branch_target wins; pending clears.
- Halt:
  - In RUN, when PC==HALT_ADDR and stall=0, the edge goes to HALTED.
  - That edge clears if_valid and drops active.
  - The IF/ID register and PC are not updated.
  - The delay slot preceding the jump has already been captured on the previous edge.
- HALTED:
  - PC frozen at HALT_ADDR; if_valid=0, active=0.
  - stall and branch_taken are ignored.
- Target alignment: low two bits of branch_target are forced to 0 before use.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN
- When defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A taken branch whose target[1:0]!=0, applied immediately or from pending, does not load PC.
  - On that edge: fetch_fault<=1, state<=HALTED, if_valid<=0, active<=0. fetch_fault stays high until reset.
- When undefined: no fetch_fault port; targets are silently word-aligned as above.

Test Plan:
- Reset release with stall=0 and ROM preloaded -> rom_addr=BFC00000 before the first edge. After edge 1: if_pc=BFC00000, if_instr=word@BFC00000, if_valid=1, rom_addr=BFC00004.
- stall=1 for 3 cycles while PC=BFC00008 -> rom_addr, if_pc=BFC00004 and if_instr hold for all 3 edges. After release, if_pc=BFC00008.
- branch_taken pulse, target BFC00040, on the edge where PC=BFC00008 and stall=0 -> if_pc=BFC00008 (delay slot), then BFC00040, then BFC00044.
- branch_taken pulse, target BFC00080, while stall=1 at PC=BFC0000C, then stall held 2 more cycles -> PC holds at BFC0000C. First free edge: if_pc=BFC0000C, PC=BFC00080.
- Jump to 0 -> delay slot captured with if_valid=1. Next edge: if_valid=0, active=0, rom_addr=00000000 thereafter, ignoring further branch pulses.
- rst_n pulsed low between edges mid-run at PC=BFC00010 -> PC=BFC00000, if_valid=0 immediately without a clock edge. With IFETCH_ALIGN_CHECK_EN defined, target BFC00042 -> fetch_fault=1, active=0.
